// File: rtl/ook_frame_tx.sv
// ook_frame_tx: keyed-carrier frame transmitter for the bell link.
// Sends one sync symbol plus DATA_W OOK data bits (MSB first), REPEATS times
// back to back, while the PLL stays locked. rf_out is the envelope gated by a
// free-running divided carrier, registered one cycle after env.
module ook_frame_tx #(
    parameter int unsigned DATA_W       = 24,
    parameter int unsigned TICK_DIV     = 30800,
    parameter int unsigned REPEATS      = 4,
    parameter int unsigned CARRIER_HALF = 0
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              pll_locked,
    input  logic              start,
    input  logic [DATA_W-1:0] code,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              env,
    output logic              rf_out
);

    localparam int unsigned TICK_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned REP_W  = (REPEATS > 1) ? $clog2(REPEATS) : 1;
    localparam int unsigned CAR_W  = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEATS - 1);
    localparam logic [CAR_W-1:0]  CAR_LAST  = CAR_W'((CARRIER_HALF > 0) ? CARRIER_HALF - 1 : 0);
    localparam logic              CAR_RESET = (CARRIER_HALF == 0);

    typedef enum logic [2:0] {
        IDLE,
        SYNC_HI,
        SYNC_LO,
        BIT_HI,
        BIT_LO
    } state_t;

    state_t             state_q, state_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [4:0]         phase_q, phase_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [CAR_W-1:0]   car_cnt_q, car_cnt_d;
    logic               car_q, car_d;
    logic               done_q, done_d;
    logic               aborted_q, aborted_d;
    logic               rf_out_q, rf_out_d;

    logic               cur_bit;
    logic [4:0]         phase_last;

    assign cur_bit = shreg_q[DATA_W-1];
    assign busy    = (state_q != IDLE);
    assign env     = (state_q == SYNC_HI) || (state_q == BIT_HI);
    assign done    = done_q;
    assign aborted = aborted_q;
    assign rf_out  = rf_out_q;

    // Phase length in ticks (minus one) for the current state and data bit.
    always_comb begin
        phase_last = 5'd0;
        case (state_q)
            SYNC_LO: phase_last = 5'd30;
            BIT_HI:  phase_last = cur_bit ? 5'd2 : 5'd0;
            BIT_LO:  phase_last = cur_bit ? 5'd0 : 5'd2;
            default: phase_last = 5'd0;
        endcase
    end

    // Next-state logic: start acceptance, tick/phase timing, bit and frame sequencing, lock abort.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        rep_d     = rep_q;
        shreg_d   = shreg_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        if (state_q == IDLE) begin
            if (start && pll_locked) begin
                shreg_d = code;
                tick_d  = '0;
                phase_d = '0;
                bit_d   = '0;
                rep_d   = '0;
                state_d = SYNC_HI;
            end
        end else if (!pll_locked) begin
            // Lock loss outranks any phase end in the same cycle.
            state_d   = IDLE;
            tick_d    = '0;
            phase_d   = '0;
            aborted_d = 1'b1;
        end else if (tick_q != TICK_LAST) begin
            tick_d = tick_q + TICK_W'(1);
        end else begin
            tick_d = '0;
            if (phase_q != phase_last) begin
                phase_d = phase_q + 5'd1;
            end else begin
                phase_d = '0;
                case (state_q)
                    SYNC_HI: state_d = SYNC_LO;
                    SYNC_LO: state_d = BIT_HI;
                    BIT_HI:  state_d = BIT_LO;
                    BIT_LO: begin
                        // Rotating keeps the latched code intact for the next repeat.
                        shreg_d = (shreg_q << 1) | (shreg_q >> (DATA_W - 1));
                        if (bit_q != BIT_LAST) begin
                            bit_d   = bit_q + BIT_W'(1);
                            state_d = BIT_HI;
                        end else begin
                            bit_d = '0;
                            if (rep_q < REP_LAST) begin
                                rep_d   = rep_q + REP_W'(1);
                                state_d = SYNC_HI;
                            end else begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Free-running carrier divider and registered carrier-gated envelope.
    always_comb begin
        car_cnt_d = car_cnt_q;
        car_d     = car_q;
        if (CARRIER_HALF == 0) begin
            car_cnt_d = '0;
            car_d     = 1'b1;
        end else if (car_cnt_q == CAR_LAST) begin
            car_cnt_d = '0;
            car_d     = ~car_q;
        end else begin
            car_cnt_d = car_cnt_q + CAR_W'(1);
        end
        rf_out_d = env & car_q;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            phase_q   <= '0;
            bit_q     <= '0;
            rep_q     <= '0;
            shreg_q   <= '0;
            car_cnt_q <= '0;
            car_q     <= CAR_RESET;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            rf_out_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            rep_q     <= rep_d;
            shreg_q   <= shreg_d;
            car_cnt_q <= car_cnt_d;
            car_q     <= car_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            rf_out_q  <= rf_out_d;
        end
    end

endmodule

// File: tb/tb_ook_frame_tx.sv
// Bench for ook_frame_tx: two instances (REPEATS=1/no carrier, REPEATS=3/carrier
// half-period 2) share stimulus; a waveform model derived from the symbol rules
// predicts every output each cycle.
module tb_ook_frame_tx;

    localparam int TD    = 4;
    localparam int W     = 24;
    localparam int FRAME = (32 + 4 * W) * TD;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  code = '0;
    logic [1:0]    busy_v, done_v, ab_v, env_v, rf_v;

    int total = 0;
    int bad   = 0;

    int busy_cnt[2];
    int done_cnt[2];
    int ab_cnt[2];

    // model state
    logic          m_act[2];
    int            m_t[2];
    int            m_k[2];
    logic [W-1:0]  m_code[2];
    logic          e_busy[2], e_env[2], e_done[2], e_ab[2], e_rf[2];

    always #5 clk = ~clk;

    ook_frame_tx #(.DATA_W(W), .TICK_DIV(TD), .REPEATS(1), .CARRIER_HALF(0)) dut_a (
        .refclk(clk), .rst(rst), .pll_locked(pll_locked), .start(start), .code(code),
        .busy(busy_v[0]), .done(done_v[0]), .aborted(ab_v[0]), .env(env_v[0]), .rf_out(rf_v[0])
    );

    ook_frame_tx #(.DATA_W(W), .TICK_DIV(TD), .REPEATS(3), .CARRIER_HALF(2)) dut_b (
        .refclk(clk), .rst(rst), .pll_locked(pll_locked), .start(start), .code(code),
        .busy(busy_v[1]), .done(done_v[1]), .aborted(ab_v[1]), .env(env_v[1]), .rf_out(rf_v[1])
    );

    function automatic int reps_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // envelope level at cycle p within a frame
    function automatic logic env_at(input logic [W-1:0] c, input int p);
        int tick, b, ph;
        tick = p / TD;
        if (tick < 1) return 1'b1;
        if (tick < 32) return 1'b0;
        b  = (tick - 32) / 4;
        ph = (tick - 32) % 4;
        if (c[W-1-b]) return (ph < 3);
        return (ph < 1);
    endfunction

    // carrier level k cycles after reset release
    function automatic logic car_at(input int d, input int k);
        int ch;
        ch = (d == 0) ? 0 : 2;
        if (ch == 0) return 1'b1;
        return ((k / ch) % 2) == 1;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_act[d] = 1'b0; m_t[d] = 0; m_k[d] = 0;
                e_busy[d] = 0; e_env[d] = 0; e_done[d] = 0; e_ab[d] = 0; e_rf[d] = 0;
            end else begin
                e_rf[d] = e_env[d] & car_at(d, m_k[d]);
                m_k[d]++;
                e_done[d] = 1'b0;
                e_ab[d]   = 1'b0;
                if (m_act[d]) begin
                    if (!pll_locked) begin
                        m_act[d] = 1'b0;
                        e_ab[d]  = 1'b1;
                    end else begin
                        m_t[d]++;
                        if (m_t[d] == reps_of(d) * FRAME) begin
                            m_act[d]  = 1'b0;
                            e_done[d] = 1'b1;
                        end
                    end
                end else if (start && pll_locked) begin
                    m_act[d]  = 1'b1;
                    m_t[d]    = 0;
                    m_code[d] = code;
                end
                e_busy[d] = m_act[d];
                e_env[d]  = m_act[d] ? env_at(m_code[d], m_t[d] % FRAME) : 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int d, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s[%0d] at %0t: got %0d expected %0d", name, d, $time, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((busy_v != 2'b00 || m_act[0] || m_act[1]) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) chk("idle_timeout", 0, n, 0);
        cyc(2);
    endtask

    int sb[2], sd[2], sa[2];

    task automatic snap();
        for (int d = 0; d < 2; d++) begin
            sb[d] = busy_cnt[d]; sd[d] = done_cnt[d]; sa[d] = ab_cnt[d];
        end
    endtask

    task automatic chk_deltas(input string tag, input int b0, input int b1,
                              input int d0, input int d1, input int a0, input int a1);
        chk({tag, "_busy"}, 0, busy_cnt[0] - sb[0], b0);
        chk({tag, "_busy"}, 1, busy_cnt[1] - sb[1], b1);
        chk({tag, "_done"}, 0, done_cnt[0] - sd[0], d0);
        chk({tag, "_done"}, 1, done_cnt[1] - sd[1], d1);
        chk({tag, "_abort"}, 0, ab_cnt[0] - sa[0], a0);
        chk({tag, "_abort"}, 1, ab_cnt[1] - sa[1], a1);
    endtask

    task automatic chk_all_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_busy"}, d, int'(busy_v[d]), 0);
            chk({tag, "_done"}, d, int'(done_v[d]), 0);
            chk({tag, "_abort"}, d, int'(ab_v[d]), 0);
            chk({tag, "_env"}, d, int'(env_v[d]), 0);
            chk({tag, "_rf"}, d, int'(rf_v[d]), 0);
        end
    endtask

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            busy_cnt[d] = 0; done_cnt[d] = 0; ab_cnt[d] = 0;
        end

        // per-cycle compare against the model
        fork
            forever begin
                @(posedge clk);
                #1;
                for (int d = 0; d < 2; d++) begin
                    chk("busy", d, int'(busy_v[d]), int'(e_busy[d]));
                    chk("env", d, int'(env_v[d]), int'(e_env[d]));
                    chk("done", d, int'(done_v[d]), int'(e_done[d]));
                    chk("aborted", d, int'(ab_v[d]), int'(e_ab[d]));
                    chk("rf_out", d, int'(rf_v[d]), int'(e_rf[d]));
                    if (busy_v[d] === 1'b1) busy_cnt[d]++;
                    if (done_v[d] === 1'b1) done_cnt[d]++;
                    if (ab_v[d] === 1'b1) ab_cnt[d]++;
                end
            end
        join_none

        // hand-computed points that pin the model
        chk("model_sync_hi", 0, int'(env_at(24'h800001, 3)), 1);
        chk("model_sync_lo", 0, int'(env_at(24'h800001, 4)), 0);
        chk("model_sync_end", 0, int'(env_at(24'h800001, 127)), 0);
        chk("model_b23_hi", 0, int'(env_at(24'h800001, 139)), 1);
        chk("model_b23_lo", 0, int'(env_at(24'h800001, 140)), 0);
        chk("model_b22_hi", 0, int'(env_at(24'h800001, 147)), 1);
        chk("model_b22_lo", 0, int'(env_at(24'h800001, 148)), 0);
        chk("model_b0_hi", 0, int'(env_at(24'h800001, 507)), 1);
        chk("model_b0_lo", 0, int'(env_at(24'h800001, 508)), 0);
        chk("model_car", 1, int'(car_at(1, 1)), 0);
        chk("model_car", 1, int'(car_at(1, 2)), 1);
        chk("model_car", 1, int'(car_at(1, 4)), 0);

        // reset held 3 cycles
        cyc(3);
        chk_all_zero("reset");
        rst = 1'b0;

        // start without lock is ignored
        start = 1'b1;
        cyc(3);
        chk("nolock_busy", 0, int'(busy_v[0]), 0);
        chk("nolock_busy", 1, int'(busy_v[1]), 0);
        start = 1'b0;
        pll_locked = 1'b1;
        cyc(2);

        // single frame / repeats with mid-frame start pulses ignored
        snap();
        code = 24'h800001;
        start = 1'b1; cyc(1); start = 1'b0;
        chk("first_env", 0, int'(env_v[0]), 1);
        chk("first_busy", 1, int'(busy_v[1]), 1);
        cyc(100);
        code = 24'hFFFFFF;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(200);
        start = 1'b1; cyc(1); start = 1'b0;
        wait_idle(3000);
        chk_deltas("frame", 512, 1536, 1, 1, 0, 0);

        // all-zero code, start held: dut_a retriggers right after done
        snap();
        code = 24'h000000;
        start = 1'b1;
        n = 0;
        while (done_v[0] !== 1'b1 && n < 1000) begin
            cyc(1);
            n++;
        end
        chk("b2b_done_seen", 0, int'(done_v[0]), 1);
        cyc(1);
        chk("b2b_rebusy", 0, int'(busy_v[0]), 1);
        start = 1'b0;
        wait_idle(3000);
        chk_deltas("b2b", 1024, 1536, 2, 1, 0, 0);

        // lock loss at busy cycle 200
        snap();
        code = 24'hA5C3F0;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(199);
        pll_locked = 1'b0;
        cyc(1);
        pll_locked = 1'b1;
        chk("lock_abort", 0, int'(ab_v[0]), 1);
        chk("lock_abort", 1, int'(ab_v[1]), 1);
        chk("lock_busy", 0, int'(busy_v[0]), 0);
        chk("lock_env", 1, int'(env_v[1]), 0);
        cyc(2);
        start = 1'b1; cyc(1); start = 1'b0;
        wait_idle(3000);
        chk_deltas("lock", 200 + 512, 200 + 1536, 1, 1, 1, 1);

        // reset mid-frame at busy cycle 300
        snap();
        code = 24'h5A0F33;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(299);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk_all_zero("midrst");
        cyc(2);
        start = 1'b1; cyc(1); start = 1'b0;
        wait_idle(3000);
        chk_deltas("midrst", 300 + 512, 300 + 1536, 1, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ook_frame_tx.md
# ook_frame_tx

Keyed-carrier frame transmitter for the bell link. It runs in the 88 MHz PLL output domain and serialises a latched bell code into fixed-width OOK symbols: one sync symbol followed by DATA_W data bits, MSB first, sent REPEATS times back to back. The output `rf_out` is the symbol envelope gated by a divided carrier and drives the transmit pin. Transmission is only allowed while the PLL reports lock.

## Interface
- `DATA_W`, 24: bell code width.
- `TICK_DIV`, 30800: clocks per symbol tick (350 µs at 88 MHz). Must be ≥ 2.
- `REPEATS`, 4: frames per start. Must be ≥ 1.
- `CARRIER_HALF`, 0: carrier half-period in clocks. 0 means no carrier; `rf_out` then equals `env`.

Ports:
- `refclk` in 1: 88 MHz clock, PLL `outclk_0`.
- `rst` in 1: synchronous, active-high reset.
- `pll_locked` in 1: PLL `locked`, already synchronous to `refclk`.
- `start` in 1: request transmission, level-sampled.
- `code` in DATA_W: bell code, sampled on an accepted start.
- `busy` out 1: transmission in progress.
- `done` out 1: one-cycle pulse on normal completion.
- `aborted` out 1: one-cycle pulse when lock is lost mid-transmission.
- `env` out 1: OOK envelope.
- `rf_out` out 1: `env` AND carrier.

## Operation
- **States:** IDLE, SYNC_HI, SYNC_LO, BIT_HI, BIT_LO.
- **Tick counter:** counts 0..TICK_DIV-1 and wraps. A phase lasts k ticks, counted by a phase tick counter.
- **SYNC symbol:** SYNC_HI lasts 1 tick, then SYNC_LO lasts 31 ticks.
- **Bit 0:** BIT_HI lasts 1 tick, BIT_LO lasts 3 ticks.
- **Bit 1:** BIT_HI lasts 3 ticks, BIT_LO lasts 1 tick.
- **Frame length:** 32 + 4·DATA_W ticks, which is 128 for the default width.
- **Envelope:** `env`=1 in SYNC_HI and BIT_HI; 0 elsewhere.
- **Start acceptance:** IDLE with `start`=1 and `pll_locked`=1:
  - latch `code` into the shift register;
  - clear the bit index, repeat counter and tick counters;
  - go to SYNC_HI.
- **Start ignored:** `start` has no effect outside IDLE or while `pll_locked`=0. There is no queueing.
- **Bit sequencing:** after SYNC_LO, go to BIT_HI for bit DATA_W-1. After each BIT_LO, move to the next lower bit.
- **End of frame:** after the BIT_LO of bit 0:
  - if the repeat counter < REPEATS-1: increment it and go to SYNC_HI, using the same latched code;
  - otherwise go to IDLE and pulse `done`.
- **Lock loss:** `pll_locked`=0 in any non-IDLE state:
  - next cycle: IDLE, `env`=0, `busy`=0, `aborted` pulses;
  - no `done`.
- **Carrier:**
  - free-running counter; toggles every CARRIER_HALF clocks; runs independently of the FSM;
  - CARRIER_HALF=0 forces the carrier to 1.
- **`rf_out`:** registered, equal to `env` & carrier, one cycle after `env`.
- **Reset:** `rst` overrides everything, including a transmission mid-frame. Next cycle:
  - state IDLE;
  - `busy`, `done`, `aborted`, `env`, `rf_out` = 0;
  - carrier counter 0, carrier level 0 (or 1 if CARRIER_HALF=0);
  - shift register and counters 0.

## Timing
- **Start to output:** `start` accepted at edge N. At N+1, `busy`=1 and `env`=1. At N+2, `rf_out` reflects `env`.
- **Phase boundaries:** each phase of k ticks holds `env` for exactly k·TICK_DIV cycles; the next phase starts on the following edge with no gap.
- **Total duration:** `busy` is high for exactly REPEATS·(32+4·DATA_W)·TICK_DIV cycles.
- **Completion:** on the edge that ends the final BIT_LO, `done`=1 and `busy`=0 in the same cycle. `done` lasts 1 cycle.
- **Back-to-back:** `start` held high re-triggers in the cycle after `done`, i.e. the first cycle back in IDLE. Minimum idle gap is 1 cycle.
- **Lock lost at edge M:** `aborted`=1 and `busy`=0 at M+1.
- **Lock vs. phase end:** lock loss in the same cycle as a phase end wins; the outcome is abort, not done.

## Test plan
- **Reset:** TICK_DIV=4, REPEATS=1, CARRIER_HALF=0; hold `rst` 3 cycles -> all outputs 0; `start` with `pll_locked`=0 -> `busy` stays 0.
- **Single frame:** `code`=24'h800001, start pulse -> `env` high 4 cycles, low 124, then 12 high / 4 low (bit 23=1), then 22×(4 high / 12 low), then 12 high / 4 low. `busy` high exactly 512 cycles, then a `done` pulse.
- **Repeats:** REPEATS=3, `code`=24'h000000 -> three identical 512-cycle frames, no gaps, 1536 busy cycles, single `done`; `start` pulses mid-frame are ignored.
- **Lock loss:** drop `pll_locked` at cycle 200 of the frame -> at 201: `env`=0, `busy`=0, `aborted`=1 for 1 cycle, no `done`; new start after relock transmits a full frame.
- **Reset mid-frame:** `rst` at cycle 300 -> next cycle all outputs 0, no `done`/`aborted`; fresh start yields a correct 512-cycle frame.
- **Carrier:** CARRIER_HALF=2 -> carrier period 4 cycles; `rf_out` = registered (`env` & carrier), 0 throughout every low phase.
